accum_array_reader: RTL
=======================

Name: accum_array_reader

Overview:
Read-side drain engine for the word-count accumulator array. On a start pulse it scans entries base..base+len-1 through the array's read port (addr in, q out, fixed read latency). Each 64-bit entry (key in [63:32], count in [31:0]) is emitted as a valid/ready stream toward the host/DMA side. An internal credit-managed FIFO absorbs the read pipeline so downstream backpressure never loses data.

Parameters:
ADDR_W, 32, width of array address and of base/len
DATA_W, 64, entry width; key = [DATA_W-1:DATA_W/2], count = [DATA_W/2-1:0]
RD_LAT, 2, cycles from mem_addr/mem_re sampled to mem_q valid; fixed, >=1
FIFO_DEPTH, 4, output buffer entries; must be >= RD_LAT+1 (power of two)
SKIP_ZERO, 1, 1 = drop entries whose count field is 0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse, begins a scan; ignored while busy=1
base  in  ADDR_W  first address, sampled on accepted start
len  in  ADDR_W  entries to scan, sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after last entry leaves FIFO (or is dropped)
mem_addr  out  ADDR_W  read address to accumulator array
mem_re  out  1  read strobe; one read per cycle when high
mem_q  in  DATA_W  read data, valid RD_LAT cycles after mem_re
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_addr  out  ADDR_W  address of emitted entry
out_key  out  DATA_W/2  key field
out_count  out  DATA_W/2  count field
emitted  out  ADDR_W  entries emitted in current/last scan (not counting skipped)

Behaviour:
- Reset (async assert, sync deassert): state IDLE; busy, done, mem_re, out_valid = 0; mem_addr, out_*, emitted = 0; FIFO empty; in-flight reads discarded.
- States: IDLE -> ISSUE (start, len!=0) -> DRAIN (all len reads issued) -> DONE (FIFO empty, pipeline empty) -> IDLE. start with len=0: IDLE -> DONE directly; done pulses the cycle after start, busy high one cycle.
- Accepted start: latch base/len, clear emitted, busy=1 next cycle.
- ISSUE: mem_re=1 only when credits available: fifo_count + in_flight < FIFO_DEPTH. Each issue increments mem_addr; address wraps modulo 2^ADDR_W.
- Read pipeline: shift register of RD_LAT stages carrying {valid, addr}; at stage end mem_q captured with its address. If SKIP_ZERO=1 and count==0, entry dropped (credit returned, not written to FIFO).
- FIFO: first-word-fall-through; out_valid = !empty; pop on out_valid & out_ready. out_* stable while out_valid & !out_ready. Simultaneous push and pop at full is legal (credit scheme prevents overflow). emitted increments on each pop.
- Full throughput: with out_ready=1 continuously, one read per cycle; first out_valid RD_LAT+1 cycles after first mem_re (1 FIFO write cycle).
- DONE: done=1 exactly one cycle, busy drops same cycle as done; emitted holds until next start.
- start during busy: ignored, no effect on scan.
- Reset mid-scan: everything returns to reset values immediately; no done pulse.

Test Plan:
- Array preloaded addr0={DEADBEEF,7}, addr1={ABADCAFE,3}, addr2={FEFEFEFE,1}, addr3={34343434,2}; start base=0 len=4, out_ready=1 -> four beats in address order with those exact key/count, mem_re high 4 consecutive cycles, done once, emitted=4.
- Same data, out_ready toggling 1 cycle on/3 off -> identical beat sequence, mem_re stalls when fifo_count+in_flight=4, no beat lost/duplicated, out_* stable during stalls.
- addr2 count=0, SKIP_ZERO=1, len=4 -> 3 beats (addr 0,1,3), emitted=3; SKIP_ZERO=0 -> 4 beats incl. {FEFEFEFE,0}.
- base=2^ADDR_W-2, len=4 -> mem_addr sequence FFFFFFFE, FFFFFFFF, 0, 1; out_addr matches.
- start with len=0 -> no mem_re, done pulse next cycle, emitted=0; start pulse while busy -> ignored, scan completes normally.
- reset asserted mid-scan after 2 beats -> out_valid, busy, mem_re low asynchronously; subsequent start base=0 len=4 yields clean 4-beat scan.

Source files
------------

// File: rtl/accum_array_reader_if.sv
// Read-port and output-stream bundle for the accumulator array drain engine.
// master: the drain engine; slave: the array read port plus the host/DMA consumer.
interface accum_array_reader_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64
);
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_re;
   logic [DATA_W-1:0]   mem_q;
   logic                out_valid;
   logic                out_ready;
   logic [ADDR_W-1:0]   out_addr;
   logic [DATA_W/2-1:0] out_key;
   logic [DATA_W/2-1:0] out_count;

   modport master (
      output mem_addr, mem_re,
      input  mem_q,
      output out_valid, out_addr, out_key, out_count,
      input  out_ready
   );

   modport slave (
      input  mem_addr, mem_re,
      output mem_q,
      input  out_valid, out_addr, out_key, out_count,
      output out_ready
   );
endinterface

// File: rtl/accum_array_reader.sv
// Drain engine for the word-count accumulator array. Scans base..base+len-1 through the
// fixed-latency read port and streams {addr, key, count} out. Reads are only issued when
// the output FIFO has room for everything already in flight, so backpressure never drops data.
module accum_array_reader #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter bit          SKIP_ZERO  = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base,
   input  logic [ADDR_W-1:0]   len,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   emitted,
   accum_array_reader_if.master bus
);

   localparam int unsigned HALF_W = DATA_W / 2;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LAST   = RD_LAT - 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   remain_q, remain_d;
   logic [ADDR_W-1:0]   emitted_q, emitted_d;

   // Read pipeline: one {valid, addr} per stage, aligned with mem_q at the last stage.
   logic [RD_LAT-1:0]   pvld_q, pvld_d;
   logic [ADDR_W-1:0]   paddr_q [RD_LAT];
   logic [ADDR_W-1:0]   paddr_d [RD_LAT];

   // Output FIFO storage (first-word-fall-through).
   logic [ADDR_W-1:0]   faddr_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]   faddr_d [FIFO_DEPTH];
   logic [DATA_W-1:0]   fdata_q [FIFO_DEPTH];
   logic [DATA_W-1:0]   fdata_d [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   int                  in_flight;
   logic                credit_ok;
   logic                issue;
   logic                push;
   logic                pop;

   // Credit accounting: reads in the pipeline already own a FIFO slot.
   always_comb begin
      in_flight = 0;
      for (int i = 0; i < int'(RD_LAT); i++) begin
         if (pvld_q[i]) in_flight = in_flight + 1;
      end
      credit_ok = (int'(cnt_q) + in_flight) < int'(FIFO_DEPTH);
      issue     = (state_q == StIssue) && credit_ok;
      push      = pvld_q[LAST] &&
                  !(SKIP_ZERO && (bus.mem_q[HALF_W-1:0] == '0));
      pop       = (cnt_q != '0) && bus.out_ready;
   end

   // Scan control FSM: next state, read address, remaining count, emitted counter.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      remain_d  = remain_q;
      emitted_d = emitted_q;
      if (pop) emitted_d = emitted_q + ADDR_W'(1);
      unique case (state_q)
         StIdle: begin
            if (start) begin
               addr_d    = base;
               remain_d  = len;
               emitted_d = '0;
               state_d   = (len == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            if (issue) begin
               addr_d   = addr_q + ADDR_W'(1);
               remain_d = remain_q - ADDR_W'(1);
               if (remain_q == ADDR_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            if ((cnt_q == '0) && (in_flight == 0)) state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Read pipeline shift and FIFO push/pop bookkeeping.
   always_comb begin
      pvld_d     = pvld_q;
      paddr_d    = paddr_q;
      pvld_d[0]  = issue;
      paddr_d[0] = addr_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         pvld_d[i]  = pvld_q[i-1];
         paddr_d[i] = paddr_q[i-1];
      end

      faddr_d  = faddr_q;
      fdata_d  = fdata_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         faddr_d[wr_ptr_q] = paddr_q[LAST];
         fdata_d[wr_ptr_q] = bus.mem_q;
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);
   end

   // State registers; async reset also discards in-flight reads and FIFO contents.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         remain_q  <= '0;
         emitted_q <= '0;
         pvld_q    <= '0;
         paddr_q   <= '{default: '0};
         faddr_q   <= '{default: '0};
         fdata_q   <= '{default: '0};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         remain_q  <= remain_d;
         emitted_q <= emitted_d;
         pvld_q    <= pvld_d;
         paddr_q   <= paddr_d;
         faddr_q   <= faddr_d;
         fdata_q   <= fdata_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.mem_addr  = addr_q;
   assign bus.mem_re    = issue;
   assign bus.out_valid = (cnt_q != '0);
   assign bus.out_addr  = faddr_q[rd_ptr_q];
   assign bus.out_key   = fdata_q[rd_ptr_q][DATA_W-1:HALF_W];
   assign bus.out_count = fdata_q[rd_ptr_q][HALF_W-1:0];
   assign busy          = (state_q != StIdle);
   assign done          = (state_q == StDone);
   assign emitted       = emitted_q;

endmodule
